// File: rtl/sdram_rsp_pipe.sv
// SDRAM read-data return path: CAS-latency tracking,
// DQ capture and a credit-throttled response FIFO.
module sdram_rsp_pipe #(
  parameter int CAS_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_issue,
  input  logic [ADDR_W-1:0] rd_issue_addr,
  input  logic [15:0]       dq_in,
  output logic              rd_credit_ok,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              overflow
);

  localparam int NS = CAS_LAT + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NS + 1);
  localparam int SW = CW + IW;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] a;
  } dl_t;

  dl_t               dl_q [NS];
  logic [15:0]       dq_r;
  logic [15:0]       mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_a [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              ovf_q;
  logic [IW-1:0]     inflight;

  logic push;
  logic pop;
  logic full;
  logic wr_en;

  assign push  = dl_q[NS-1].v;
  assign pop   = rsp_valid & rsp_ready;
  assign full  = (count == CW'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);

  // Pad register and CAS-latency delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_r <= '0;
      for (int i = 0; i < NS; i++)
        dl_q[i] <= '0;
    end else begin
      dq_r    <= dq_in;
      dl_q[0] <= {rd_issue, rd_issue_addr};
      for (int i = 1; i < NS; i++)
        dl_q[i] <= dl_q[i-1];
    end
  end

  // FIFO storage, written on an accepted capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_a[i] <= '0;
      end
    end else if (wr_en) begin
      mem_d[wr_ptr] <= dq_r;
      mem_a[wr_ptr] <= dl_q[NS-1].a;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop)
        ovf_q <= 1'b1;
    end
  end

  // Number of READs still travelling down the delay line
  always_comb begin
    inflight = '0;
    for (int i = 0; i < NS; i++)
      inflight = inflight + IW'(dl_q[i].v);
  end

  assign rd_credit_ok =
    (SW'(count) + SW'(inflight)) < SW'(FIFO_DEPTH);

  assign rsp_valid = (count != '0);
  assign rsp_rdata = mem_d[rd_ptr];
  assign rsp_addr  = mem_a[rd_ptr];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sdram_rsp_pipe.sv
// Bench for sdram_rsp_pipe: vector table, corner
// sequences and a randomized run against a queue model.
module tb_sdram_rsp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iss   [2];
  logic [23:0] iaddr [2];
  logic [15:0] dq    [2];
  logic        rdy   [2];
  logic        cred  [2];
  logic        vld   [2];
  logic        ovf   [2];
  logic [15:0] rdata [2];
  logic [23:0] raddr [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_rsp_pipe #(.CAS_LAT(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .rd_issue(iss[0]), .rd_issue_addr(iaddr[0]),
    .dq_in(dq[0]), .rd_credit_ok(cred[0]),
    .rsp_valid(vld[0]), .rsp_ready(rdy[0]),
    .rsp_rdata(rdata[0]), .rsp_addr(raddr[0]),
    .overflow(ovf[0])
  );

  sdram_rsp_pipe #(.CAS_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd_issue(iss[1]), .rd_issue_addr(iaddr[1]),
    .dq_in(dq[1]), .rd_credit_ok(cred[1]),
    .rsp_valid(vld[1]), .rsp_ready(rdy[1]),
    .rsp_rdata(rdata[1]), .rsp_addr(raddr[1]),
    .overflow(ovf[1])
  );

  typedef struct {
    int          d;
    logic [23:0] addr;
    logic [15:0] data;
    int          lat;
  } vec_t;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    int          t;
  } item_t;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] va(int b, int i);
    return 24'(b * 4096 + i * 17 + 3);
  endfunction

  function automatic logic [15:0] vd(int b, int i);
    return 16'(b * 256 + i + 1);
  endfunction

  task automatic chk_rst(input int d);
    chk("rst_valid", 32'(vld[d]), 0);
    chk("rst_rdata", 32'(rdata[d]), 0);
    chk("rst_addr", 32'(raddr[d]), 0);
    chk("rst_ovf", 32'(ovf[d]), 0);
    chk("rst_credit", 32'(cred[d]), 1);
  endtask

  // Four legal back-to-back issues, ready low; returns at
  // the start of the cycle where all four are queued.
  task automatic fill4(input int d, input int b);
    for (int c = 0; c < 7; c++) begin
      chk("fill_credit", 32'(cred[d]), 32'(c < 4));
      iss[d]   = (c < 4);
      iaddr[d] = va(b, c);
      dq[d]    = (c >= 2 && c < 6) ? vd(b, c - 2)
                                   : 16'hDEAD;
      tick();
    end
    iss[d] = 1'b0;
    chk("fill_valid", 32'(vld[d]), 1);
    chk("fill_ovf", 32'(ovf[d]), 0);
    chk("fill_credit_full", 32'(cred[d]), 0);
  endtask

  task automatic drain(input int d, input int b,
                       input int first, input int n,
                       input logic ovf_exp);
    for (int i = first; i < first + n; i++) begin
      chk("drain_valid", 32'(vld[d]), 1);
      chk("drain_data", 32'(rdata[d]), 32'(vd(b, i)));
      chk("drain_addr", 32'(raddr[d]), 32'(va(b, i)));
      if (i > first)
        chk("drain_credit", 32'(cred[d]), 1);
      rdy[d] = 1'b1;
      tick();
    end
    rdy[d] = 1'b0;
    chk("drain_empty", 32'(vld[d]), 0);
    chk("drain_ovf", 32'(ovf[d]), 32'(ovf_exp));
  endtask

  // A fifth capture aimed at a full FIFO, with or
  // without a pop in the capture cycle.
  task automatic fifth(input int d, input int b,
                       input logic pop);
    iss[d]   = 1'b1;
    iaddr[d] = va(b, 4);
    tick();
    iss[d] = 1'b0;
    tick();
    dq[d] = vd(b, 4);
    tick();
    dq[d] = 16'hDEAD;
    chk("fifth_ovf_pre", 32'(ovf[d]), 0);
    chk("fifth_head", 32'(rdata[d]), 32'(vd(b, 0)));
    rdy[d] = pop;
    tick();
    rdy[d] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("fifth_ovf", 32'(ovf[d]), 32'(!pop));
      chk("fifth_credit", 32'(cred[d]), 0);
      chk("fifth_hold", 32'(rdata[d]),
          32'(vd(b, pop ? 1 : 0)));
      tick();
    end
    drain(d, b, pop ? 1 : 0, 4, !pop);
  endtask

  task automatic rand_run(input int d, input int n,
                          input bit dense);
    item_t pend[$];
    item_t vis[$];
    item_t it;
    int    cas;
    bit    cexp;
    cas = d + 2;
    for (int c = 0; c < n + 20; c++) begin
      while (pend.size() > 0 &&
             pend[0].t + cas + 2 == c)
        vis.push_back(pend.pop_front());
      cexp = (pend.size() + vis.size()) < 4;
      chk("rnd_valid", 32'(vld[d]), 32'(vis.size() != 0));
      chk("rnd_credit", 32'(cred[d]), 32'(cexp));
      chk("rnd_ovf", 32'(ovf[d]), 0);
      if (vis.size() > 0) begin
        chk("rnd_data", 32'(rdata[d]), 32'(vis[0].data));
        chk("rnd_addr", 32'(raddr[d]), 32'(vis[0].addr));
      end
      rdy[d] = (dense || c >= n) ? 1'b1
                                 : 1'($urandom % 2);
      if (rdy[d] && vis.size() > 0)
        void'(vis.pop_front());
      dq[d] = 16'($urandom);
      foreach (pend[i])
        if (pend[i].t + cas == c)
          dq[d] = pend[i].data;
      iss[d] = (c < n) && cexp &&
               (dense || ($urandom % 3 != 0));
      iaddr[d] = 24'($urandom);
      if (iss[d]) begin
        it.addr = iaddr[d];
        it.data = 16'($urandom);
        it.t    = c;
        pend.push_back(it);
      end
      tick();
    end
    iss[d] = 1'b0;
    rdy[d] = 1'b0;
    chk("rnd_end_empty", 32'(vld[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   d;
    vt[0] = '{0, 24'h012345, 16'hBEEF, 4};
    vt[1] = '{0, 24'hFFFFFF, 16'hFFFF, 4};
    vt[2] = '{0, 24'h800001, 16'h8001, 4};
    vt[3] = '{1, 24'h012345, 16'hBEEF, 5};
    vt[4] = '{1, 24'hABCDEF, 16'h1234, 5};

    for (int i = 0; i < 2; i++) begin
      iss[i] = 1'b0; iaddr[i] = '0;
      dq[i] = '0;    rdy[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_rst(0);
    chk_rst(1);
    #2 rst_n = 1'b1;
    tick();
    chk_rst(0);

    foreach (vt[j]) begin
      d        = vt[j].d;
      iss[d]   = 1'b1;
      iaddr[d] = vt[j].addr;
      dq[d]    = 16'hA5A5;
      for (int k = 1; k <= vt[j].lat; k++) begin
        tick();
        iss[d] = 1'b0;
        dq[d]  = (k == d + 2) ? vt[j].data : 16'h5A5A;
        if (k == 1)
          chk("sr_credit", 32'(cred[d]), 1);
        chk("sr_valid", 32'(vld[d]), 32'(k == vt[j].lat));
        if (k == vt[j].lat) begin
          chk("sr_addr", 32'(raddr[d]), 32'(vt[j].addr));
          chk("sr_data", 32'(rdata[d]), 32'(vt[j].data));
          rdy[d] = 1'b1;
        end
      end
      tick();
      rdy[d] = 1'b0;
      chk("sr_popped", 32'(vld[d]), 0);
    end

    fill4(0, 0);
    drain(0, 0, 0, 4, 1'b0);

    fill4(0, 1);
    fifth(0, 1, 1'b1);

    fill4(0, 2);
    fifth(0, 2, 1'b0);

    for (int c = 0; c < 8; c++) begin
      iss[0]   = (c < 3) || c == 6 || c == 7;
      iaddr[0] = va(3, c);
      dq[0]    = vd(3, c);
      tick();
    end
    iss[0] = 1'b0;
    chk("pre_rst_ovf", 32'(ovf[0]), 1);
    chk("pre_rst_valid", 32'(vld[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_rst(0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      dq[0] = 16'($urandom);
      chk("post_rst_valid", 32'(vld[0]), 0);
      chk("post_rst_credit", 32'(cred[0]), 1);
      chk("post_rst_ovf", 32'(ovf[0]), 0);
    end

    rand_run(0, 30, 1'b1);
    rand_run(0, 300, 1'b0);
    rand_run(1, 30, 1'b1);
    rand_run(1, 300, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_rsp_pipe.md
# sdram_rsp_pipe

Read-data return path of the SDRAM controller. Tracks every READ command issued by the controller FSM through a CAS-latency delay line, captures the SDRAM DQ word when it arrives, and queues it with its originating address in a small response FIFO. The host drains the FIFO with a valid/ready handshake. The FSM is throttled by a credit signal so that the FIFO never overflows.

## Interface
- CAS_LAT, 2, SDRAM CAS latency in clocks; legal values are 2 and 3.
- FIFO_DEPTH, 4, response FIFO entries; must be a power of two, at least 2.
- ADDR_W, 24, host address width (ROW+COL+BANK bits).

- clk  in  1  controller clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rd_issue  in  1  one-cycle pulse from the FSM in the cycle it drives a READ command onto the SDRAM bus.
- rd_issue_addr  in  ADDR_W  host address of that READ; sampled only when rd_issue=1.
- dq_in  in  16  SDRAM DQ input, raw from the pad.
- rd_credit_ok  out  1  the FSM may assert rd_issue this cycle.
- rsp_valid  out  1  FIFO head holds a response.
- rsp_ready  in  1  host accepts the head.
- rsp_rdata  out  16  read data at the FIFO head.
- rsp_addr  out  ADDR_W  address at the FIFO head.
- overflow  out  1  sticky error flag: a capture was dropped.

## Operation
- **I/O stage.** dq_in is registered into dq_r every clock, unconditionally.
- **Delay line.** A shift register of CAS_LAT+1 stages carries {valid, addr}.
  - Stage 0 loads {rd_issue, rd_issue_addr} every clock.
  - The final stage marks the cycle in which dq_r holds the word for that READ.
- **Capture.** When the final stage is valid, {addr, dq_r} is pushed into the FIFO. Captures may occur on consecutive cycles.
- **FIFO.**
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - The count register is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
  - rsp_valid = (count != 0).
  - Pop when rsp_valid && rsp_ready.
  - rsp_rdata and rsp_addr are driven from the head entry. They are not meaningful when rsp_valid=0.
  - rsp_rdata and rsp_addr must hold stable while rsp_valid=1 and rsp_ready=0.
- **Credit.**
  - inflight is the number of valid delay-line stages.
  - rd_credit_ok = (count + inflight) < FIFO_DEPTH, computed combinationally from registers only.
  - The FSM must not assert rd_issue while rd_credit_ok=0.
- **Boundary conditions.**
  - Push and pop in the same cycle: the count is unchanged. This also holds when count=FIFO_DEPTH; the push is accepted in that case.
  - Push while full with no pop: the entry is dropped and overflow is set. overflow stays 1 until reset. This can only occur if the FSM violates the credit rule.
  - Pop while empty: not possible, because rsp_valid=0 gates the pop.
  - No bypass: a word pushed in cycle N is first visible on rsp_valid in cycle N+1.
  - Reset mid-operation: all in-flight READs and queued responses are discarded immediately.
- **Reset values.**
  - Outputs: rsp_valid=0, rsp_rdata=0, rsp_addr=0, overflow=0, rd_credit_ok=1.
  - Internal state: delay line all invalid, pointers and count 0, FIFO storage 0, dq_r=0.

## Timing
- rd_issue is high in cycle T.
- The SDRAM drives the word on dq_in in cycle T+CAS_LAT.
- dq_r holds the word in cycle T+CAS_LAT+1, and the push happens at the end of that cycle.
- With the FIFO empty, rsp_valid rises in cycle T+CAS_LAT+2. The issue-to-response latency is therefore CAS_LAT+2 clocks (4 at the default).
- Back-to-back READs issued in T, T+1, … produce back-to-back rsp_valid beats with rsp_ready held at 1.
- rd_credit_ok reflects issues and pops from the previous edge. An rd_issue in cycle T consumes credit visible from cycle T+1.

## Test plan
- **Reset.** Assert rst_n=0 mid-burst, with 2 READs in flight and 3 entries queued. Required: all outputs at reset values; no rsp_valid after release; rd_credit_ok=1.
- **Single read, CAS_LAT=2.** rd_issue at T with addr=0x012345; dq_in=0xBEEF at T+2. Required: rsp_valid=1 at T+4 with rsp_addr=0x012345, rsp_rdata=0xBEEF; a pop at T+4 gives rsp_valid=0 at T+5.
- **Burst of 4 with rsp_ready=0.** Four issues at T..T+3 with data 0x0001..0x0004. Required:
  - rd_credit_ok=0 from T+4.
  - count=4, overflow=0.
  - Raising rsp_ready then returns 0x0001..0x0004 in order on 4 consecutive cycles.
  - rd_credit_ok returns to 1 after the first pop.
- **Pointer wrap.** Stream 10 reads with rsp_ready=1. Required: 10 responses in issue order, data and address matched, overflow=0.
- **Full with simultaneous push/pop.** FIFO holds 4 entries; the 5th capture lands in the same cycle as a pop. Required: count stays 4, nothing is lost, overflow=0.
- **Credit violation and CAS_LAT=3.**
  - Force a push into a full FIFO with no pop. Required: overflow=1 from the next cycle and stays 1; FIFO contents unchanged.
  - Rerun the single-read scenario with CAS_LAT=3. Required: rsp_valid at T+5.
